// File: rtl/sdram_avm_wrapper.sv
// sdram_avm_wrapper: turns single-cycle write/read request pulses from the SDRAM
// test controller into held Avalon-MM master transfers that honour waitrequest
// and readdatavalid. The last read word is held on o_data for the HEX display.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_write, i_read       request pulses (write wins when both are high)
//   i_addr, i_data        word address / write data, sampled with the request
//   o_data, o_valid       last read data, 1-cycle pulse when it is refreshed
//   o_wr_done             1-cycle pulse once the slave accepts a write
//   o_busy                high while a transfer is outstanding (requests dropped)
//   o_err                 1-cycle pulse when readdatavalid never arrives
//   avm_*                 Avalon-MM master port towards the SDRAM controller
module sdram_avm_wrapper #(
  parameter int unsigned ADDR_W  = 26,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_write,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_data,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_valid,
  output logic                o_wr_done,
  output logic                o_busy,
  output logic                o_err,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  input  logic                avm_waitrequest
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BE_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RD_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;
  logic              valid_q, valid_d;
  logic              wr_done_q, wr_done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state logic; pulse outputs default low, everything else holds.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    wr_done_d = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_write) begin
          addr_d  = i_addr;
          wdata_d = i_data;
          wr_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = S_WR;
        end else if (i_read) begin
          addr_d  = i_addr;
          rd_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = S_RD;
        end
      end

      S_WR: begin
        if (!avm_waitrequest) begin
          wr_d      = 1'b0;
          wr_done_d = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_RD: begin
        if (!avm_waitrequest) begin
          rd_d  = 1'b0;
          cnt_d = '0;
          // Zero-latency slave: data returns with the accept cycle.
          if (avm_readdatavalid) begin
            rdata_d = avm_readdata;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_RD_WAIT;
          end
        end
      end

      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // TIMEOUT edges after acceptance with no data: give up, keep o_data.
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      valid_q   <= 1'b0;
      wr_done_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      wr_done_q <= wr_done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_data         = rdata_q;
  assign o_valid        = valid_q;
  assign o_wr_done      = wr_done_q;
  assign o_busy         = busy_q;
  assign o_err          = err_q;
  assign avm_address    = addr_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = {BE_W{1'b1}};

endmodule

// File: tb/tb_sdram_avm_wrapper.sv
// Testbench for sdram_avm_wrapper: directed scenarios plus randomized write/read
// traffic against an Avalon slave whose storage is a bench-side word memory.
module tb_sdram_avm_wrapper;

  localparam int unsigned ADDR_W  = 26;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 8;

  logic                i_clk = 1'b0;
  logic                i_rst_n;
  logic                i_write, i_read;
  logic [ADDR_W-1:0]   i_addr;
  logic [DATA_W-1:0]   i_data;
  logic [DATA_W-1:0]   o_data;
  logic                o_valid, o_wr_done, o_busy, o_err;
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read, avm_write;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_readdatavalid, avm_waitrequest;

  always #5 i_clk = ~i_clk;

  sdram_avm_wrapper #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_write(i_write), .i_read(i_read), .i_addr(i_addr), .i_data(i_data),
    .o_data(o_data), .o_valid(o_valid), .o_wr_done(o_wr_done),
    .o_busy(o_busy), .o_err(o_err),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest(avm_waitrequest)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [DATA_W-1:0] o_last;
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] pool [4] = '{26'h0000010, 26'h3fffff0, 26'h1555555, 26'h2aaaaaa};

  // Slave storage: written words, otherwise an address-derived pattern.
  function automatic logic [DATA_W-1:0] slave_data(input logic [ADDR_W-1:0] a);
    if (mem.exists(a)) return mem[a];
    return DATA_W'(a) ^ 16'h5a5a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(o_busy), 32'd0);
    check({tag, "_wr"}, 32'(avm_write), 32'd0);
    check({tag, "_rd"}, 32'(avm_read), 32'd0);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_done"}, 32'(o_wr_done), 32'd0);
    check({tag, "_err"}, 32'(o_err), 32'd0);
    check({tag, "_data"}, 32'(o_data), 32'(o_last));
    check({tag, "_be"}, 32'(avm_byteenable), 32'h3);
  endtask

  // Write with nw stall cycles; both=1 also pulses i_read alongside.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int nw, input bit both);
    i_write = 1'b1; i_read = both; i_addr = a; i_data = d;
    tick();
    i_write = 1'b0; i_read = 1'b0;
    i_addr = ADDR_W'($urandom); i_data = DATA_W'($urandom);
    for (int k = 0; k <= nw; k++) begin
      check("wr_strobe", 32'(avm_write), 32'd1);
      check("wr_addr", 32'(avm_address), 32'(a));
      check("wr_data", 32'(avm_writedata), 32'(d));
      check("wr_no_read", 32'(avm_read), 32'd0);
      check("wr_done_early", 32'(o_wr_done), 32'd0);
      check("wr_busy", 32'(o_busy), 32'd1);
      avm_waitrequest = (k < nw);
      tick();
    end
    avm_waitrequest = 1'b0;
    check("wr_done", 32'(o_wr_done), 32'd1);
    check("wr_release", 32'(avm_write), 32'd0);
    check("wr_no_valid", 32'(o_valid), 32'd0);
    mem[a] = d;
    tick();
    check_idle("after_wr");
  endtask

  // Read with nw stall cycles and data lat edges after acceptance
  // (0 = same edge, > TIMEOUT = never). poke re-requests while waiting.
  task automatic do_read(input logic [ADDR_W-1:0] a, input int nw, input int lat,
                         input bit poke);
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] exp;
    acc_addr = '0;
    i_read = 1'b1; i_addr = a;
    tick();
    i_read = 1'b0; i_addr = ADDR_W'($urandom);
    for (int k = 0; k <= nw; k++) begin
      check("rd_strobe", 32'(avm_read), 32'd1);
      check("rd_addr", 32'(avm_address), 32'(a));
      check("rd_no_write", 32'(avm_write), 32'd0);
      check("rd_busy", 32'(o_busy), 32'd1);
      avm_waitrequest = (k < nw);
      if (k == nw) begin
        acc_addr = avm_address;
        if (lat == 0) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = slave_data(acc_addr);
        end
      end
      tick();
    end
    avm_waitrequest = 1'b0;
    exp = slave_data(a);
    for (int j = 1; j <= lat && j <= int'(TIMEOUT); j++) begin
      check("rd_release", 32'(avm_read), 32'd0);
      check("rd_wait_valid", 32'(o_valid), 32'd0);
      check("rd_wait_err", 32'(o_err), 32'd0);
      check("rd_wait_busy", 32'(o_busy), 32'd1);
      i_read = poke && (j == 1);
      i_addr = a ^ 26'h1;
      if (j == lat) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = slave_data(acc_addr);
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata = DATA_W'($urandom);
      end
      tick();
    end
    i_read = 1'b0;
    if (lat <= int'(TIMEOUT)) begin
      check("rd_valid", 32'(o_valid), 32'd1);
      check("rd_data", 32'(o_data), 32'(exp));
      check("rd_no_err", 32'(o_err), 32'd0);
      o_last = exp;
    end else begin
      check("rd_timeout_err", 32'(o_err), 32'd1);
      check("rd_timeout_valid", 32'(o_valid), 32'd0);
      check("rd_timeout_data", 32'(o_data), 32'(o_last));
    end
    check("rd_done_busy", 32'(o_busy), 32'd0);
    avm_readdatavalid = 1'b0;
    tick();
    check_idle("after_rd");
  endtask

  // Idle cycles, optionally with stray readdatavalid that must be ignored.
  task automatic idle(input int n, input bit stray);
    for (int i = 0; i < n; i++) begin
      avm_readdatavalid = stray && ($urandom_range(0, 1) == 1);
      avm_readdata = DATA_W'($urandom);
      tick();
      check("idle_valid", 32'(o_valid), 32'd0);
      check("idle_data", 32'(o_data), 32'(o_last));
    end
    avm_readdatavalid = 1'b0;
    tick();
    check_idle("idle");
  endtask

  initial begin
    int op, nw, lat;
    logic [ADDR_W-1:0] a;
    i_rst_n = 1'b0; i_write = 1'b0; i_read = 1'b0; i_addr = '0; i_data = '0;
    avm_readdata = '0; avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    o_last = '0;
    tick(); tick();
    check_idle("reset");
    i_rst_n = 1'b1;
    tick();
    check_idle("post_reset");

    // Basic write then read with data two edges after acceptance.
    do_write(26'h0000010, 16'hBEEF, 0, 1'b0);
    do_read(26'h0000010, 0, 2, 1'b0);
    // Write stalled three cycles.
    do_write(26'h3fffff0, 16'h1234, 3, 1'b0);
    // Simultaneous write and read: only the write issues.
    do_write(26'h1555555, 16'hA5C3, 1, 1'b1);
    // Read re-requested while waiting for data is dropped.
    do_read(26'h3fffff0, 1, 4, 1'b1);
    idle(3, 1'b1);
    // Timeout, then a normal read; also zero-latency and last-chance reads.
    do_read(26'h1555555, 0, 100, 1'b0);
    do_read(26'h1555555, 2, 3, 1'b0);
    do_read(26'h0000010, 0, 0, 1'b0);
    do_read(26'h3fffff0, 0, int'(TIMEOUT), 1'b0);

    // Randomized traffic over a small address pool.
    for (int t = 0; t < 40; t++) begin
      op  = int'($urandom_range(0, 1));
      a   = pool[$urandom_range(0, 3)];
      nw  = int'($urandom_range(0, 3));
      lat = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 6));
      if (op == 0) do_write(a, DATA_W'($urandom), nw, $urandom_range(0, 3) == 0);
      else         do_read(a, nw, lat, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)), 1'b1);
    end

    // Asynchronous reset during a stalled write.
    i_write = 1'b1; i_addr = 26'h2aaaaaa; i_data = 16'h7777;
    tick();
    i_write = 1'b0;
    avm_waitrequest = 1'b1;
    check("rst_pre_wr", 32'(avm_write), 32'd1);
    tick();
    check("rst_pre_busy", 32'(o_busy), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    o_last = '0;
    check_idle("async_rst");
    tick();
    i_rst_n = 1'b1;
    avm_waitrequest = 1'b0;
    tick();
    check_idle("rst_release");
    tick();
    check_idle("rst_release2");
    do_read(26'h0000010, 1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
